// File: rtl/shared_mem_scheduler.sv
// Shared-memory scheduler: serializes core write bursts (one core pair per cycle, broadcast
// to all three BRAM copies) and read bursts (six cores per cycle) onto the BRAM ports.
module shared_mem_scheduler #(
  parameter int NUM_CORES = 24,
  parameter int ADDR_W    = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_CORES-1:0]    writeReq_i,
  input  logic [NUM_CORES-1:0]    readReq_i,
  input  logic [NUM_CORES*32-1:0] marIn_i,
  input  logic [NUM_CORES*32-1:0] mdrIn_i,
  output logic [5:0]              bramEn_o,
  output logic [5:0]              bramWe_o,
  output logic [6*ADDR_W-1:0]     bramAddr_o,
  output logic [6*32-1:0]         bramDin_o,
  input  logic [6*32-1:0]         bramDout_i,
  output logic [NUM_CORES*32-1:0] readData_o,
  output logic [NUM_CORES-1:0]    finishedRead_o,
  output logic [NUM_CORES-1:0]    finishedWrite_o,
  output logic                    busy_o
);
  localparam int NUM_PAIRS  = NUM_CORES / 2;
  localparam int NUM_GROUPS = NUM_CORES / 6;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;
  state_t state_q, state_d;

  logic [NUM_CORES-1:0]    pend_q, pend_d, served_q, served_d;
  logic [NUM_CORES-1:0]    wr_iss_q, wr_iss_d, rd_iss1_q, rd_iss1_d, rd_iss2_q;
  logic [NUM_CORES-1:0]    fin_wr_q, fin_rd_q;
  logic [NUM_CORES*32-1:0] rdata_q, rdata_d;
  logic [5:0]              en_q, en_d, we_q, we_d;
  logic [6*ADDR_W-1:0]     addr_q, addr_d;
  logic [6*32-1:0]         din_q, din_d;

  logic [NUM_CORES-1:0]    inflight, blocked, elig_wr, elig_rd, issue;
  logic [NUM_CORES-1:0]    wr_mask, rd_mask;
  logic                    a_pend, b_pend, a_en, b_en;
  logic [ADDR_W-1:0]       a_addr, b_addr;
  logic [31:0]             a_data, b_data;
  logic [5:0]              rd_lane_en;
  logic [6*ADDR_W-1:0]     rd_lane_addr;
  logic                    unused_mar;

  // Upper MAR bits carry no meaning for the BRAM word address.
  assign unused_mar = ^marIn_i;

  // Cores still in a pipeline stage are excluded until their served bit takes over.
  assign inflight = wr_iss_q | fin_wr_q | rd_iss1_q | rd_iss2_q | fin_rd_q;
  assign blocked  = served_q | inflight;
  assign elig_wr  = writeReq_i & ~blocked;
  assign elig_rd  = readReq_i & ~blocked;
  assign served_d = (served_q | fin_wr_q | fin_rd_q) & (writeReq_i | readReq_i);

  always_comb begin
    wr_mask = '0;
    a_pend  = 1'b0;
    b_pend  = 1'b0;
    a_addr  = '0;
    b_addr  = '0;
    a_data  = '0;
    b_data  = '0;
    for (int k = NUM_PAIRS-1; k >= 0; k--) begin
      if (pend_q[2*k] || pend_q[2*k+1]) begin
        wr_mask          = '0;
        wr_mask[2*k]     = pend_q[2*k];
        wr_mask[2*k+1]   = pend_q[2*k+1];
        a_pend           = pend_q[2*k];
        b_pend           = pend_q[2*k+1];
        a_addr           = marIn_i[64*k +: ADDR_W];
        b_addr           = marIn_i[64*k+32 +: ADDR_W];
        a_data           = mdrIn_i[64*k +: 32];
        b_data           = mdrIn_i[64*k+32 +: 32];
      end
    end
  end

  // Same-address pair: port B alone carries the write, so core 2k+1 wins.
  assign b_en = b_pend;
  assign a_en = a_pend & ~(b_pend && (a_addr == b_addr));

  always_comb begin
    rd_mask      = '0;
    rd_lane_en   = '0;
    rd_lane_addr = '0;
    for (int g = NUM_GROUPS-1; g >= 0; g--) begin
      if (|pend_q[6*g +: 6]) begin
        rd_mask            = '0;
        rd_mask[6*g +: 6]  = pend_q[6*g +: 6];
        rd_lane_en         = pend_q[6*g +: 6];
        for (int j = 0; j < 6; j++) begin
          rd_lane_addr[j*ADDR_W +: ADDR_W] =
            pend_q[6*g+j] ? marIn_i[(6*g+j)*32 +: ADDR_W] : '0;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    issue     = '0;
    wr_iss_d  = '0;
    rd_iss1_d = '0;
    en_d      = '0;
    we_d      = '0;
    addr_d    = '0;
    din_d     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|elig_wr) begin
          pend_d  = elig_wr;
          state_d = ST_WRITE;
        end else if (|elig_rd) begin
          pend_d  = elig_rd;
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        issue    = wr_mask;
        wr_iss_d = wr_mask;
        for (int b = 0; b < 3; b++) begin
          en_d[2*b]                         = a_en;
          en_d[2*b+1]                       = b_en;
          addr_d[(2*b)*ADDR_W +: ADDR_W]    = a_en ? a_addr : '0;
          addr_d[(2*b+1)*ADDR_W +: ADDR_W]  = b_en ? b_addr : '0;
          din_d[(2*b)*32 +: 32]             = a_en ? a_data : '0;
          din_d[(2*b+1)*32 +: 32]           = b_en ? b_data : '0;
        end
        we_d = en_d;
      end
      ST_READ: begin
        issue     = rd_mask;
        rd_iss1_d = rd_mask;
        en_d      = rd_lane_en;
        addr_d    = rd_lane_addr;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE) begin
      pend_d = pend_q & ~issue;
      if (pend_d == '0) state_d = ST_IDLE;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (rd_iss2_q[i]) rdata_d[i*32 +: 32] = bramDout_i[(i%6)*32 +: 32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      served_q  <= '0;
      wr_iss_q  <= '0;
      rd_iss1_q <= '0;
      rd_iss2_q <= '0;
      fin_wr_q  <= '0;
      fin_rd_q  <= '0;
      rdata_q   <= '0;
      en_q      <= '0;
      we_q      <= '0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      served_q  <= served_d;
      wr_iss_q  <= wr_iss_d;
      rd_iss1_q <= rd_iss1_d;
      rd_iss2_q <= rd_iss1_q;
      fin_wr_q  <= wr_iss_q;
      fin_rd_q  <= rd_iss2_q;
      rdata_q   <= rdata_d;
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
    end
  end

  assign bramEn_o        = en_q;
  assign bramWe_o        = we_q;
  assign bramAddr_o      = addr_q;
  assign bramDin_o       = din_q;
  assign readData_o      = rdata_q;
  assign finishedRead_o  = fin_rd_q;
  assign finishedWrite_o = fin_wr_q;
  assign busy_o          = (state_q != ST_IDLE) | (|inflight);

endmodule

// File: tb/tb_shared_mem_scheduler.sv
// Directed bench for shared_mem_scheduler with a behavioural model of the three dual-port BRAMs.
module tb_shared_mem_scheduler;
  localparam int NC = 24;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   writeReq, readReq;
  logic [NC*32-1:0] marIn, mdrIn;
  logic [5:0]      bramEn, bramWe;
  logic [47:0]     bramAddr;
  logic [191:0]    bramDin, bramDout;
  logic [NC*32-1:0] readData;
  logic [NC-1:0]   finishedRead, finishedWrite;
  logic            busy;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  shared_mem_scheduler #(.NUM_CORES(NC), .ADDR_W(8)) dut (
    .clk_i(clk), .reset_i(reset), .writeReq_i(writeReq), .readReq_i(readReq),
    .marIn_i(marIn), .mdrIn_i(mdrIn), .bramEn_o(bramEn), .bramWe_o(bramWe),
    .bramAddr_o(bramAddr), .bramDin_o(bramDin), .bramDout_i(bramDout),
    .readData_o(readData), .finishedRead_o(finishedRead),
    .finishedWrite_o(finishedWrite), .busy_o(busy)
  );

  // Three BRAM copies, contents initialised to addr+0x100, registered read port.
  logic [31:0] mem [3][256];
  always @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 3; b++)
        for (int a = 0; a < 256; a++) mem[b][a] <= 32'h100 + 32'(a);
      bramDout <= '0;
    end else begin
      for (int l = 0; l < 6; l++) begin
        if (bramEn[l]) begin
          if (bramWe[l]) mem[l/2][bramAddr[l*8 +: 8]] <= bramDin[l*32 +: 32];
          bramDout[l*32 +: 32] <= mem[l/2][bramAddr[l*8 +: 8]];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    writeReq = '0;
    readReq  = '0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; writeReq = '0; readReq = '0; marIn = '0; mdrIn = '0;
    step(); step();
    checks++;
    if ({bramEn, bramWe, bramAddr, bramDin} !== '0) begin
      errors++; $display("FAIL reset_bram: got en=%b we=%b addr=%h", bramEn, bramWe, bramAddr);
    end
    checks++;
    if ({finishedRead, finishedWrite, busy} !== '0) begin
      errors++; $display("FAIL reset_flags: got fr=%h fw=%h busy=%b expected 0", finishedRead, finishedWrite, busy);
    end
    checks++;
    if (readData !== '0) begin
      errors++; $display("FAIL reset_rdata: got nonzero readData expected 0");
    end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || bramEn !== 6'b0) begin
      errors++; $display("FAIL idle_quiet: got busy=%b en=%b expected 0", busy, bramEn);
    end
  endtask

  task automatic test_single_write();
    int pulses = 0;
    int port_act = 0;
    marIn[5*32 +: 32] = 32'h12; mdrIn[5*32 +: 32] = 32'hDEADBEEF; writeReq[5] = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy: got %b expected 1", busy); end
    step();
    checks++;
    if (bramEn !== 6'b101010) begin errors++; $display("FAIL sw_en: got %b expected 101010", bramEn); end
    checks++;
    if (bramWe !== 6'b101010) begin errors++; $display("FAIL sw_we: got %b expected 101010", bramWe); end
    checks++;
    if (bramAddr !== 48'h120012001200) begin
      errors++; $display("FAIL sw_addr: got %h expected 120012001200", bramAddr);
    end
    checks++;
    if (bramDin !== {32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0}) begin
      errors++; $display("FAIL sw_din: got %h", bramDin);
    end
    checks++;
    if (finishedWrite !== 24'h0) begin errors++; $display("FAIL sw_early: got %h expected 0", finishedWrite); end
    step();
    checks++;
    if (finishedWrite !== 24'h000020) begin errors++; $display("FAIL sw_fin: got %h expected 000020", finishedWrite); end
    repeat (6) begin
      step();
      if (finishedWrite != 24'h0) pulses++;
      if (bramEn != 6'b0) port_act++;
    end
    checks++;
    if (pulses !== 0 || port_act !== 0) begin
      errors++; $display("FAIL sw_served: got pulses=%0d port_cycles=%0d expected 0", pulses, port_act);
    end
    writeReq[5] = 1'b0;
    step(); step();
    writeReq[5] = 1'b1;
    step(); step(); step();
    checks++;
    if (finishedWrite !== 24'h000020) begin errors++; $display("FAIL sw_rereq: got %h expected 000020", finishedWrite); end
    settle();
  endtask

  task automatic test_full_read();
    logic [5:0]    exp_en;
    logic [NC-1:0] exp_fin;
    for (int i = 0; i < NC; i++) marIn[i*32 +: 32] = 32'h80 + 32'(i);
    readReq = '1;
    for (int c = 1; c <= 8; c++) begin
      step();
      exp_en = (c >= 2 && c <= 5) ? 6'h3F : 6'h00;
      case (c)
        4: exp_fin = 24'h00003F;
        5: exp_fin = 24'h000FC0;
        6: exp_fin = 24'h03F000;
        7: exp_fin = 24'hFC0000;
        default: exp_fin = 24'h0;
      endcase
      checks++;
      if (bramEn !== exp_en) begin errors++; $display("FAIL fr_en c=%0d: got %b expected %b", c, bramEn, exp_en); end
      checks++;
      if (finishedRead !== exp_fin) begin
        errors++; $display("FAIL fr_fin c=%0d: got %h expected %h", c, finishedRead, exp_fin);
      end
      if (c == 2) begin
        checks++;
        if (bramAddr !== 48'h858483828180 || bramWe !== 6'b0) begin
          errors++; $display("FAIL fr_addr: got %h we=%b expected 858483828180 we=0", bramAddr, bramWe);
        end
      end
      if (c >= 4 && c <= 7) begin
        for (int j = 0; j < 6; j++) begin
          checks++;
          if (readData[(6*(c-4)+j)*32 +: 32] !== 32'h180 + 32'(6*(c-4)+j)) begin
            errors++; $display("FAIL fr_data core=%0d: got %h expected %h", 6*(c-4)+j,
                               readData[(6*(c-4)+j)*32 +: 32], 32'h180 + 32'(6*(c-4)+j));
          end
        end
      end
      if (c == 7) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL fr_busy_last: got %b expected 1", busy); end
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL fr_busy_end: got %b expected 0", busy); end
    settle();
  endtask

  task automatic test_sparse_write();
    marIn[0*32 +: 32]  = 32'h21; mdrIn[0*32 +: 32]  = 32'hA0A0;
    marIn[23*32 +: 32] = 32'h22; mdrIn[23*32 +: 32] = 32'hB0B0;
    writeReq[0] = 1'b1; writeReq[23] = 1'b1;
    step();
    step();
    checks++;
    if (bramEn !== 6'b010101 || bramAddr !== 48'h002100210021) begin
      errors++; $display("FAIL sp_pair0: got en=%b addr=%h expected 010101/002100210021", bramEn, bramAddr);
    end
    checks++;
    if (bramDin[31:0] !== 32'hA0A0) begin errors++; $display("FAIL sp_din0: got %h expected a0a0", bramDin[31:0]); end
    step();
    checks++;
    if (bramEn !== 6'b101010 || bramAddr !== 48'h220022002200) begin
      errors++; $display("FAIL sp_pair11: got en=%b addr=%h expected 101010/220022002200", bramEn, bramAddr);
    end
    checks++;
    if (finishedWrite !== 24'h000001) begin errors++; $display("FAIL sp_fin0: got %h expected 000001", finishedWrite); end
    step();
    checks++;
    if (finishedWrite !== 24'h800000 || bramEn !== 6'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL sp_fin23: got fw=%h en=%b busy=%b expected 800000/0/1", finishedWrite, bramEn, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0 || finishedWrite !== 24'h0) begin
      errors++; $display("FAIL sp_idle1: got busy=%b fw=%h expected 0", busy, finishedWrite);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL sp_idle2: got %b expected 0", busy); end
    settle();
  endtask

  task automatic test_conflict();
    marIn[2*32 +: 32] = 32'h40; mdrIn[2*32 +: 32] = 32'h1;
    marIn[3*32 +: 32] = 32'h40; mdrIn[3*32 +: 32] = 32'h2;
    writeReq[2] = 1'b1; writeReq[3] = 1'b1;
    step(); step();
    checks++;
    if (bramEn !== 6'b101010 || bramWe !== 6'b101010) begin
      errors++; $display("FAIL cf_en: got en=%b we=%b expected 101010", bramEn, bramWe);
    end
    checks++;
    if (bramDin !== {32'h2, 32'h0, 32'h2, 32'h0, 32'h2, 32'h0}) begin
      errors++; $display("FAIL cf_din: got %h", bramDin);
    end
    step();
    checks++;
    if (finishedWrite !== 24'h00000C) begin errors++; $display("FAIL cf_fin: got %h expected 00000c", finishedWrite); end
    settle();
    marIn[0*32 +: 32] = 32'h40; readReq[0] = 1'b1;
    repeat (4) step();
    checks++;
    if (finishedRead !== 24'h000001 || readData[31:0] !== 32'h2) begin
      errors++; $display("FAIL cf_read: got fr=%h data=%h expected 000001/2", finishedRead, readData[31:0]);
    end
    settle();
  endtask

  task automatic test_priority();
    int early = 0;
    marIn[1*32 +: 32] = 32'h90; readReq[1] = 1'b1;
    marIn[7*32 +: 32] = 32'h33; mdrIn[7*32 +: 32] = 32'h77; writeReq[7] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c < 6 && finishedRead != 24'h0) early++;
      if (c == 2) begin
        checks++;
        if (bramEn !== 6'b101010 || bramWe !== 6'b101010) begin
          errors++; $display("FAIL pr_write_first: got en=%b we=%b expected 101010", bramEn, bramWe);
        end
      end
      if (c == 3) begin
        checks++;
        if (finishedWrite !== 24'h000080 || bramEn !== 6'b0) begin
          errors++; $display("FAIL pr_wfin: got fw=%h en=%b expected 000080/0", finishedWrite, bramEn);
        end
      end
      if (c == 4) begin
        checks++;
        if (bramEn !== 6'b000010 || bramWe !== 6'b0 || bramAddr[15:8] !== 8'h90) begin
          errors++; $display("FAIL pr_read_port: got en=%b we=%b a1=%h expected 000010/0/90", bramEn, bramWe, bramAddr[15:8]);
        end
      end
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL pr_early_read: got %0d early pulses expected 0", early); end
    checks++;
    if (finishedRead !== 24'h000002 || readData[63:32] !== 32'h190) begin
      errors++; $display("FAIL pr_rfin: got fr=%h data=%h expected 000002/190", finishedRead, readData[63:32]);
    end
    settle();
  endtask

  task automatic test_reset_mid_read();
    logic [NC-1:0] exp_fin;
    for (int i = 0; i < NC; i++) marIn[i*32 +: 32] = 32'h80 + 32'(i);
    readReq = '1;
    step(); step(); step();
    checks++;
    if (bramEn !== 6'h3F) begin errors++; $display("FAIL rm_pre: got %b expected 111111", bramEn); end
    reset = 1'b1;
    step();
    checks++;
    if ({bramEn, bramWe, bramAddr, bramDin} !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL rm_bram: got en=%b busy=%b expected 0", bramEn, busy);
    end
    checks++;
    if (finishedRead !== 24'h0 || finishedWrite !== 24'h0 || readData !== '0) begin
      errors++; $display("FAIL rm_flags: got fr=%h fw=%h expected 0", finishedRead, finishedWrite);
    end
    reset = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      step();
      case (r)
        4: exp_fin = 24'h00003F;
        5: exp_fin = 24'h000FC0;
        6: exp_fin = 24'h03F000;
        7: exp_fin = 24'hFC0000;
        default: exp_fin = 24'h0;
      endcase
      checks++;
      if (finishedRead !== exp_fin) begin
        errors++; $display("FAIL rm_refin r=%0d: got %h expected %h", r, finishedRead, exp_fin);
      end
    end
    checks++;
    if (readData[23*32 +: 32] !== 32'h197 || readData[0 +: 32] !== 32'h180) begin
      errors++; $display("FAIL rm_data: got c23=%h c0=%h expected 197/180", readData[23*32 +: 32], readData[31:0]);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full_read();
    test_sparse_write();
    test_conflict();
    test_priority();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
